// File: rtl/sw_pkg.sv
// ============================================================================
//  Module   : sw_pkg
//  Purpose  : Shared flit-type codes, arbiter states and logic levels.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package sw_pkg;

   localparam logic [1:0] NONE = 2'b00;
   localparam logic [1:0] HEAD = 2'b01;
   localparam logic [1:0] BODY = 2'b10;
   localparam logic [1:0] TAIL = 2'b11;

   localparam logic ASSERT = 1'b1;
   localparam logic NEGATE = 1'b0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ACK  = 2'd1,
      XFER = 2'd2
   } state_e;

endpackage

`default_nettype wire

// File: rtl/sw_rr_pick.sv
// ============================================================================
//  Module   : sw_rr_pick
//  Purpose  : Combinational round-robin picker, search upward from ptr.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sw_rr_pick
   import sw_pkg::*;
#(
   parameter int NIN = 4,
   parameter int GW  = 2
) (
   input  logic [NIN-1:0] req,
   input  logic [GW-1:0]  ptr,
   output logic [GW-1:0]  winner,
   output logic           any
);

   int idx;

   // Scan offsets from farthest to nearest so the nearest requester wins.
   always_comb begin
      winner = ptr;
      any    = NEGATE;
      idx    = 0;
      for (int i = NIN - 1; i >= 0; i--) begin
         idx = int'(ptr) + i;
         if (idx >= NIN) begin
            idx = idx - NIN;
         end
         if (req[idx]) begin
            winner = GW'(idx);
            any    = ASSERT;
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/sw_oarb.sv
// ============================================================================
//  Module   : sw_oarb
//  Purpose  : Output-port arbiter/sequencer; locks the port per packet.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sw_oarb
   import sw_pkg::*;
#(
   parameter int NIN = 4,
   parameter int W   = 32
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic [NIN-1:0]              req,
   input  logic [NIN-1:0]              re,
   input  logic [2*NIN-1:0]            ptype,
   input  logic [NIN*W-1:0]            din,
   output logic [NIN-1:0]              ack,
   output logic [W-1:0]                dout,
   output logic [1:0]                  dtype,
   output logic                        we,
   output logic                        busy,
   output logic [$clog2(NIN)-1:0]      gnt,
   output logic [15:0]                 pkt_cnt
);

   localparam int GW = $clog2(NIN);

   state_e          state_q, state_d;
   logic [GW-1:0]   gnt_q, gnt_d;
   logic [GW-1:0]   ptr_q, ptr_d;
   logic [15:0]     pkt_cnt_q, pkt_cnt_d;

   logic [GW-1:0]   pick_win;
   logic            pick_any;
   logic            sel_re;
   logic [1:0]      sel_type;

   sw_rr_pick #(
      .NIN (NIN),
      .GW  (GW)
   ) u_pick (
      .req    (req),
      .ptr    (ptr_q),
      .winner (pick_win),
      .any    (pick_any)
   );

   always_comb begin
      state_d   = state_q;
      gnt_d     = gnt_q;
      ptr_d     = ptr_q;
      pkt_cnt_d = pkt_cnt_q;
      ack       = '0;
      we        = NEGATE;
      sel_re    = re[gnt_q];
      sel_type  = ptype[2*int'(gnt_q) +: 2];
      dout      = din[W*int'(gnt_q) +: W];
      dtype     = sel_type;

      case (state_q)
         IDLE: begin
            if (pick_any) begin
               gnt_d   = pick_win;
               state_d = ACK;
            end
         end
         ACK: begin
            // A TAIL read here is forwarded but never releases the port.
            ack[gnt_q] = ASSERT;
            we         = sel_re;
            state_d    = XFER;
         end
         XFER: begin
            we = sel_re;
            if (sel_re && (sel_type == TAIL)) begin
               state_d   = IDLE;
               ptr_d     = (gnt_q == GW'(NIN - 1)) ? '0 : gnt_q + 1'b1;
               pkt_cnt_d = pkt_cnt_q + 16'd1;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         gnt_q     <= '0;
         ptr_q     <= '0;
         pkt_cnt_q <= '0;
      end else begin
         state_q   <= state_d;
         gnt_q     <= gnt_d;
         ptr_q     <= ptr_d;
         pkt_cnt_q <= pkt_cnt_d;
      end
   end

   assign busy    = (state_q != IDLE);
   assign gnt     = gnt_q;
   assign pkt_cnt = pkt_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_sw_oarb.sv
// ============================================================================
//  Module   : tb_sw_oarb
//  Purpose  : Directed self-checking bench for the sw_oarb output arbiter.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_sw_oarb;

   localparam int NIN = 4;
   localparam int W   = 32;

   localparam logic [1:0] T_NONE = 2'b00;
   localparam logic [1:0] T_HEAD = 2'b01;
   localparam logic [1:0] T_BODY = 2'b10;
   localparam logic [1:0] T_TAIL = 2'b11;

   logic              clk = 1'b0;
   logic              rst;
   logic [NIN-1:0]    req;
   logic [NIN-1:0]    re;
   logic [1:0]        pt [NIN];
   logic [W-1:0]      dn [NIN];
   logic [2*NIN-1:0]  ptype;
   logic [NIN*W-1:0]  din;
   logic [NIN-1:0]    ack;
   logic [W-1:0]      dout;
   logic [1:0]        dtype;
   logic              we;
   logic              busy;
   logic [1:0]        gnt;
   logic [15:0]       pkt_cnt;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   always_comb begin
      for (int i = 0; i < NIN; i++) begin
         ptype[2*i +: 2] = pt[i];
         din[W*i +: W]   = dn[i];
      end
   end

   sw_oarb #(.NIN(NIN), .W(W)) dut (
      .clk     (clk),
      .rst     (rst),
      .req     (req),
      .re      (re),
      .ptype   (ptype),
      .din     (din),
      .ack     (ack),
      .dout    (dout),
      .dtype   (dtype),
      .we      (we),
      .busy    (busy),
      .gnt     (gnt),
      .pkt_cnt (pkt_cnt)
   );

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic clear_inputs();
      req = '0;
      re  = '0;
      for (int i = 0; i < NIN; i++) begin
         pt[i] = T_NONE;
         dn[i] = '0;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      clear_inputs();
      step();
      step();
      #1;
      vectors++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL reset_ack got %b want %b", ack, 4'b0000); end
      vectors++; if (we !== 1'b0) begin miscompares++; $display("FAIL reset_we got %b want %b", we, 1'b0); end
      vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want %b", busy, 1'b0); end
      vectors++; if (pkt_cnt !== 16'h0000) begin miscompares++; $display("FAIL reset_pkt_cnt got %h want %h", pkt_cnt, 16'h0000); end
      vectors++; if (gnt !== 2'd0) begin miscompares++; $display("FAIL reset_gnt got %0d want %0d", gnt, 0); end
      rst = 1'b0;
   endtask

   task automatic test_basic();
      req = 4'b0010;
      #1;
      vectors++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL basic_idle_ack got %b want %b", ack, 4'b0000); end
      step();
      req = '0; re = 4'b0010; pt[1] = T_HEAD; dn[1] = 32'hA;
      #1;
      vectors++; if (ack !== 4'b0010) begin miscompares++; $display("FAIL basic_ack got %b want %b", ack, 4'b0010); end
      vectors++; if (gnt !== 2'd1) begin miscompares++; $display("FAIL basic_gnt got %0d want %0d", gnt, 1); end
      vectors++; if (we !== 1'b1 || dout !== 32'hA) begin miscompares++; $display("FAIL basic_head got we=%b dout=%h want we=1 dout=a", we, dout); end
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL basic_busy got %b want %b", busy, 1'b1); end
      step();
      pt[1] = T_BODY; dn[1] = 32'hB;
      #1;
      vectors++; if (ack !== 4'b0000) begin miscompares++; $display("FAIL basic_ack_once got %b want %b", ack, 4'b0000); end
      vectors++; if (we !== 1'b1 || dout !== 32'hB) begin miscompares++; $display("FAIL basic_body got we=%b dout=%h want we=1 dout=b", we, dout); end
      step();
      pt[1] = T_TAIL; dn[1] = 32'hC;
      #1;
      vectors++; if (we !== 1'b1 || dout !== 32'hC || dtype !== T_TAIL) begin miscompares++; $display("FAIL basic_tail got we=%b dout=%h dtype=%b want we=1 dout=c dtype=11", we, dout, dtype); end
      step();
      re = '0; pt[1] = T_NONE;
      #1;
      vectors++; if (busy !== 1'b0 || we !== 1'b0) begin miscompares++; $display("FAIL basic_release got busy=%b we=%b want busy=0 we=0", busy, we); end
      vectors++; if (pkt_cnt !== 16'd1) begin miscompares++; $display("FAIL basic_pkt_cnt got %0d want %0d", pkt_cnt, 1); end
      vectors++; if (dut.ptr_q !== 2'd2) begin miscompares++; $display("FAIL basic_ptr got %0d want %0d", dut.ptr_q, 2); end
   endtask

   task automatic test_round_robin();
      int exp_order [5] = '{0, 1, 2, 3, 0};
      int e;
      rst = 1'b1;
      step();
      rst = 1'b0;
      req = 4'b1111;
      for (int k = 0; k < 5; k++) begin
         e = exp_order[k];
         step();
         re = 4'b0001 << e; pt[e] = T_HEAD; dn[e] = 32'h100 + k;
         #1;
         vectors++; if (ack !== (4'b0001 << e) || gnt !== 2'(e)) begin miscompares++; $display("FAIL rr_grant%0d got ack=%b gnt=%0d want ack=%b gnt=%0d", k, ack, gnt, 4'b0001 << e, e); end
         step();
         pt[e] = T_TAIL; dn[e] = 32'h200 + k;
         #1;
         vectors++; if (ack !== 4'b0000 || we !== 1'b1 || dout !== 32'h200 + k) begin miscompares++; $display("FAIL rr_tail%0d got ack=%b we=%b dout=%h want ack=0000 we=1 dout=%h", k, ack, we, dout, 32'h200 + k); end
         step();
         re = '0; pt[e] = T_NONE;
         #1;
         vectors++; if (ack !== 4'b0000 || busy !== 1'b0) begin miscompares++; $display("FAIL rr_gap%0d got ack=%b busy=%b want ack=0000 busy=0", k, ack, busy); end
      end
      req = '0;
      vectors++; if (pkt_cnt !== 16'd5) begin miscompares++; $display("FAIL rr_pkt_cnt got %0d want %0d", pkt_cnt, 5); end
   endtask

   task automatic test_ignore_other_re();
      req = 4'b0100;
      step();
      req = '0; re = 4'b0100; pt[2] = T_HEAD; dn[2] = 32'h22;
      #1;
      vectors++; if (ack !== 4'b0100 || we !== 1'b1 || dout !== 32'h22) begin miscompares++; $display("FAIL ign_head got ack=%b we=%b dout=%h want ack=0100 we=1 dout=22", ack, we, dout); end
      step();
      re = 4'b0001; pt[0] = T_TAIL; dn[0] = 32'hDEAD; pt[2] = T_BODY;
      #1;
      vectors++; if (we !== 1'b0 || gnt !== 2'd2) begin miscompares++; $display("FAIL ign_other_re got we=%b gnt=%0d want we=0 gnt=2", we, gnt); end
      step();
      #1;
      vectors++; if (busy !== 1'b1 || gnt !== 2'd2) begin miscompares++; $display("FAIL ign_no_release got busy=%b gnt=%0d want busy=1 gnt=2", busy, gnt); end
      re = 4'b0101; dn[2] = 32'h23;
      #1;
      vectors++; if (we !== 1'b1 || dout !== 32'h23 || dtype !== T_BODY) begin miscompares++; $display("FAIL ign_own_body got we=%b dout=%h dtype=%b want we=1 dout=23 dtype=10", we, dout, dtype); end
      step();
      re = 4'b0100; pt[2] = T_TAIL; dn[2] = 32'h24; pt[0] = T_NONE;
      #1;
      vectors++; if (dtype !== T_TAIL || dout !== 32'h24) begin miscompares++; $display("FAIL ign_tail got dtype=%b dout=%h want dtype=11 dout=24", dtype, dout); end
      step();
      re = '0; pt[2] = T_NONE;
      #1;
      vectors++; if (busy !== 1'b0 || pkt_cnt !== 16'd6) begin miscompares++; $display("FAIL ign_done got busy=%b pkt_cnt=%0d want busy=0 pkt_cnt=6", busy, pkt_cnt); end
   endtask

   task automatic test_tail_in_ack();
      req = 4'b0001;
      step();
      req = '0; re = 4'b0001; pt[0] = T_TAIL; dn[0] = 32'h55;
      #1;
      vectors++; if (ack !== 4'b0001 || we !== 1'b1 || dtype !== T_TAIL) begin miscompares++; $display("FAIL tack_ack got ack=%b we=%b dtype=%b want ack=0001 we=1 dtype=11", ack, we, dtype); end
      step();
      pt[0] = T_BODY;
      #1;
      vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL tack_locked got busy=%b want 1", busy); end
      step();
      pt[0] = T_TAIL;
      #1;
      vectors++; if (busy !== 1'b1 || we !== 1'b1) begin miscompares++; $display("FAIL tack_xfer_tail got busy=%b we=%b want busy=1 we=1", busy, we); end
      step();
      re = '0; pt[0] = T_NONE;
      #1;
      vectors++; if (busy !== 1'b0 || pkt_cnt !== 16'd7) begin miscompares++; $display("FAIL tack_done got busy=%b pkt_cnt=%0d want busy=0 pkt_cnt=7", busy, pkt_cnt); end
   endtask

   task automatic test_reset_mid_xfer();
      req = 4'b1000;
      step();
      req = '0; re = 4'b1000; pt[3] = T_HEAD;
      step();
      pt[3] = T_BODY;
      #1;
      vectors++; if (busy !== 1'b1 || gnt !== 2'd3) begin miscompares++; $display("FAIL rmid_pre got busy=%b gnt=%0d want busy=1 gnt=3", busy, gnt); end
      rst = 1'b1;
      step();
      #1;
      vectors++; if (busy !== 1'b0 || we !== 1'b0) begin miscompares++; $display("FAIL rmid_state got busy=%b we=%b want busy=0 we=0", busy, we); end
      vectors++; if (pkt_cnt !== 16'd0 || dut.ptr_q !== 2'd0 || gnt !== 2'd0) begin miscompares++; $display("FAIL rmid_regs got pkt_cnt=%0d ptr=%0d gnt=%0d want 0 0 0", pkt_cnt, dut.ptr_q, gnt); end
      rst = 1'b0;
      re = '0; pt[3] = T_NONE;
   endtask

   task automatic test_cnt_wrap();
      force dut.pkt_cnt_q = 16'hFFFF;
      step();
      release dut.pkt_cnt_q;
      #1;
      vectors++; if (pkt_cnt !== 16'hFFFF) begin miscompares++; $display("FAIL wrap_preload got %h want %h", pkt_cnt, 16'hFFFF); end
      req = 4'b0100;
      step();
      req = '0; re = 4'b0100; pt[2] = T_HEAD;
      step();
      pt[2] = T_TAIL;
      step();
      re = '0; pt[2] = T_NONE;
      #1;
      vectors++; if (pkt_cnt !== 16'h0000 || busy !== 1'b0) begin miscompares++; $display("FAIL wrap_cnt got pkt_cnt=%h busy=%b want 0000 0", pkt_cnt, busy); end
   endtask

   initial begin
      rst = 1'b1;
      clear_inputs();
      @(negedge clk);
      test_reset();
      test_basic();
      test_round_robin();
      test_ignore_other_re();
      test_tail_in_ack();
      test_reset_mid_xfer();
      test_cnt_wrap();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired after %0d vectors", vectors);
      $fatal(1, "watchdog");
   end

endmodule

`default_nettype wire

// File: doc/sw_oarb.md
# sw_oarb

Output-port arbiter and sequencer for the wormhole switch. Shares one output port among NIN input buffer managers: picks one requesting input round-robin, issues its single-cycle `ack`, steers that input's flits onto the output while its manager reads, and releases the port when the TAIL flit passes. One instance per output port, between the input buffer managers and the output link/FIFO.

## Interface

Parameters:
- NIN, 4: number of input ports competing for this output (2..8).
- W, 32: flit payload width.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high; clock clk.
- req  in  NIN  req[i]: input i has a head flit routed to this port.
- re  in  NIN  re[i]: read enable from input i's buffer manager (flit consumed this cycle).
- ptype  in  NIN×2  flit type at head of input i's buffer.
- din  in  NIN×W  flit payload at head of input i's buffer (show-ahead).
- ack  out  NIN  one-hot grant pulse to the chosen buffer manager.
- dout  out  W  forwarded payload.
- dtype  out  2  forwarded flit type.
- we  out  1  write strobe to output link; `dout`/`dtype` valid when high.
- busy  out  1  port locked to a packet (state ≠ IDLE).
- gnt  out  log2(NIN)  index of current owner.
- pkt_cnt  out  16  packets forwarded since reset.

## Operation

- States: IDLE, ACK, XFER.
- IDLE: if `req` ≠ 0, winner = first set bit of `req` searching upward from `ptr`, wrapping modulo NIN; register `gnt` ← winner; → ACK. Otherwise stay.
- ACK: `ack[gnt]` = 1 for exactly this cycle; → XFER unconditionally. The manager reads the HEAD flit in this cycle.
- XFER: if `re[gnt]` && `ptype[gnt]` == TAIL → IDLE, `ptr` ← (gnt+1) mod NIN, `pkt_cnt` += 1 (wraps at 2^16). Otherwise stay.
- Datapath (both ACK and XFER): `we` = `re[gnt]`; `dout` = `din[gnt]`; `dtype` = `ptype[gnt]`. In IDLE `we` = 0, `dout`/`dtype` are don't-care.
- `re[i]` for i ≠ gnt is ignored.
- Packets are ≥2 flits (HEAD…TAIL). A TAIL flit seen in ACK does not end the packet.
- `req` is sampled only in IDLE. `req[gnt]` dropping in ACK/XFER does not cancel the grant or lock.
- Flit-type codes: NONE=2'b00, HEAD=2'b01, BODY=2'b10, TAIL=2'b11.

## Timing

- Reset values: state IDLE, `ptr` 0, `gnt` 0, `ack` 0, `we` 0, `busy` 0, `pkt_cnt` 0.
- Reset mid-packet: return to IDLE next edge. The packet is abandoned; the managers share `rst`.
- Request to `ack`: `req` seen in IDLE at edge n → `ack` high during cycle n+1.
- `ack`/`we`/`dout`/`dtype` are combinational from registered state, `gnt` and inputs. No extra pipeline; flit written the same cycle it is read.
- Tail read at edge n → IDLE at n+1. New arbitration is sampled at edge n+1, so the next `ack` comes in cycle n+2. Minimum one idle cycle between packets on a port.
- `busy` = 1 from the cycle after the IDLE→ACK edge through the cycle the TAIL is read.
- Simultaneous requests resolve by `ptr` only. After serving input k, input k has lowest priority.

## Structure

- Shared package `sw_pkg`: flit-type constants (NONE/HEAD/BODY/TAIL), state enum for IDLE/ACK/XFER, and ASSERT/NEGATE.
- Sub-module `sw_rr_pick`: combinational round-robin picker. Inputs `req` and `ptr`; outputs winner index and `any`.
- The remainder is the FSM, the `ptr`/`gnt`/`pkt_cnt` registers and the NIN:1 mux.

## Test plan

- Reset, then `req`=4'b0010 → `ack`=4'b0010 for one cycle two edges later. Manager reads HEAD, BODY, TAIL with `din`=0xA,0xB,0xC → `we` high 3 cycles, `dout` 0xA,0xB,0xC, `pkt_cnt`=1, `ptr`=2.
- `req`=4'b1111 held, 2-flit packets → grants in order 0,1,2,3,0, each `ack` one-hot, no overlap.
- During input 2's XFER, `re[0]` pulses with a TAIL on input 0 → `we` tracks `re[2]` only. Owner unchanged; no release.
- TAIL presented in ACK cycle, then BODY, then TAIL in XFER → release only on the XFER TAIL. `pkt_cnt`+1.
- `rst` asserted mid-XFER → next cycle state IDLE, `we`=0, `busy`=0, `pkt_cnt`=0, `ptr`=0.
- Preload `pkt_cnt`=0xFFFF via 65535 packets (or force), one more packet → `pkt_cnt`=0x0000.
